// File: rtl/sprite_shift_unit.sv
// Per-scanline sprite output stage: slot X counters, pattern shifters
// and lowest-index opaque-pixel priority select feeding the pixel mux.
module sprite_shift_unit #(
    parameter int NUM_SLOTS = 8,
    parameter int SLOT_W    = 3,
    parameter int X_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_en,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [1:0]        load_sel,
    input  logic [7:0]        load_data,
    input  logic              sprite0_in,
    input  logic              next_pixel,
    output logic [3:0]        sprite_pixel,
    output logic              sprite_priority,
    output logic              sprite0_pixel
);

    logic [NUM_SLOTS-1:0] r_valid;
    logic [NUM_SLOTS-1:0] r_prio;
    logic [NUM_SLOTS-1:0] r_flip;
    logic [1:0]           r_pal  [NUM_SLOTS];
    logic [X_W-1:0]       r_xcnt [NUM_SLOTS];
    logic [7:0]           r_lo   [NUM_SLOTS];
    logic [7:0]           r_hi   [NUM_SLOTS];
    logic                 r_s0;

    logic [NUM_SLOTS-1:0] w_act;
    logic [NUM_SLOTS-1:0] w_sel;
    logic [3:0]           w_pix;
    logic                 w_prio;
    logic                 w_s0;

    function automatic logic [7:0] f_rev(input logic [7:0] d);
        for (int b = 0; b < 8; b++) f_rev[b] = d[7-b];
    endfunction

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign w_act[g] = r_valid[g] && (r_xcnt[g] == '0);
        assign w_sel[g] = load_en && (load_slot == SLOT_W'(g));
    end

    // Scan high to low so the lowest opaque active slot is left standing.
    always_comb begin
        w_pix  = 4'd0;
        w_prio = 1'b0;
        w_s0   = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_act[i] && (r_hi[i][7] || r_lo[i][7])) begin
                w_pix  = {r_pal[i], r_hi[i][7], r_lo[i][7]};
                w_prio = r_prio[i];
                w_s0   = (i == 0) ? r_s0 : 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_prio  <= '0;
            r_flip  <= '0;
            r_s0    <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_pal[i]  <= '0;
                r_xcnt[i] <= '0;
                r_lo[i]   <= '0;
                r_hi[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (next_pixel && r_valid[i]) begin
                    if (w_act[i]) begin
                        r_lo[i] <= {r_lo[i][6:0], 1'b0};
                        r_hi[i] <= {r_hi[i][6:0], 1'b0};
                    end else begin
                        r_xcnt[i] <= r_xcnt[i] - X_W'(1);
                    end
                end
                // A load overrides the advance of the same field only.
                if (w_sel[i]) begin
                    unique case (load_sel)
                        2'd0: begin
                            r_pal[i]   <= load_data[1:0];
                            r_prio[i]  <= load_data[5];
                            r_flip[i]  <= load_data[6];
                            r_valid[i] <= 1'b1;
                        end
                        2'd1: r_xcnt[i] <= X_W'(load_data);
                        2'd2: r_lo[i] <= r_flip[i] ? f_rev(load_data) : load_data;
                        2'd3: r_hi[i] <= r_flip[i] ? f_rev(load_data) : load_data;
                    endcase
                end
            end
            if (w_sel[0] && (load_sel == 2'd0)) r_s0 <= sprite0_in;
            if (clear) r_valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sprite_pixel    <= 4'd0;
            sprite_priority <= 1'b0;
            sprite0_pixel   <= 1'b0;
        end else if (next_pixel) begin
            sprite_pixel    <= w_pix;
            sprite_priority <= w_prio;
            sprite0_pixel   <= w_s0;
        end
    end

endmodule

// File: doc/sprite_shift_unit.md
# sprite_shift_unit

Parametrised per-scanline sprite output stage of the PPU. It holds up to `NUM_SLOTS` sprites fetched during the previous horizontal blank. Each slot has an X delay counter and a pair of 8-bit pattern shift registers. On every pixel strobe it emits the highest-priority opaque sprite pixel, its background-priority bit and a sprite-0 marker. Its outputs feed the pixel multiplexer next to the background shifters.

## Interface
Parameters:
- `NUM_SLOTS`, 8: number of sprite slots (1..16).
- `SLOT_W`, 3: slot index width; must equal clog2(`NUM_SLOTS`), minimum 1.
- `X_W`, 8: X delay counter width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `clear`  in  1  pulse; invalidates all slots. Issued at the start of the sprite fetch phase.
- `load_en`  in  1  write strobe for one slot field.
- `load_slot`  in  SLOT_W  target slot; values ≥ `NUM_SLOTS` are ignored.
- `load_sel`  in  2  field select: 0 = attribute, 1 = X position, 2 = pattern low, 3 = pattern high.
- `load_data`  in  8  field data.
- `sprite0_in`  in  1  sampled with an attribute load to slot 0; marks that slot as OAM sprite 0.
- `next_pixel`  in  1  one-cycle pixel advance strobe.
- `sprite_pixel`  out  4  {palette[1:0], pat_hi_bit, pat_lo_bit}. Value 0 means transparent.
- `sprite_priority`  out  1  attribute bit 5 of the winning slot (1 = behind background).
- `sprite0_pixel`  out  1  winning opaque pixel comes from slot 0 and slot 0 is flagged sprite 0.

## Operation
- Per-slot state:
  - `valid`
  - `pal[1:0]` from attr[1:0]
  - `prio` from attr[5]
  - `flip_h` from attr[6]
  - `xcnt[X_W-1:0]`
  - `pat_lo[7:0]`, `pat_hi[7:0]`
  - slot 0 only: `s0` flag
- Attribute load (sel 0):
  - writes `pal`, `prio` and `flip_h`, and sets `valid`.
  - For slot 0, also writes `s0 <= sprite0_in`.
- X load (sel 1) writes `xcnt <= load_data`, zero-extended or truncated to `X_W`.
- Pattern loads (sel 2/3):
  - store `load_data` bit-reversed when the slot's stored `flip_h` = 1.
  - The attribute must therefore be loaded before the patterns. A later attribute write does not re-flip patterns already stored.
- `clear` sets every `valid` to 0. No other fields change.
- Slot behaviour on `next_pixel`:
  - Invalid slots hold all state.
  - Valid slot with `xcnt` ≠ 0: decrements `xcnt`; the slot is not active.
  - Valid slot with `xcnt` = 0: active. `pat_lo` and `pat_hi` shift left by one with 0 fill; bit 7 is the current pixel.
  - After 8 shifts the pattern is all zero, so the slot is transparent for the rest of the line. The counter stays at 0 and never wraps.
- Winner selection:
  - Candidates are active slots with {pat_hi[7], pat_lo[7]} ≠ 0.
  - The lowest slot index among candidates wins.
  - With no candidate, all three outputs go to 0.
- Pixel placement: a sprite with X = x outputs pattern pixel k (left-to-right after flip) on strobe number x+k+1 counted from the first strobe after loading.

## Timing
- All outputs are registered and reset to 0.
- Outputs update only in a cycle with `next_pixel` = 1. They capture the winner computed from slot state before that cycle's shift or decrement, and hold until the next strobe.
- Latency: pixel data is visible on the outputs the cycle after the strobe.
- `load_en` and `next_pixel` in the same cycle:
  - The written field takes the load value and suppresses that field's shift or decrement.
  - Other fields and other slots advance normally.
  - Winner evaluation uses the pre-load state.
- `clear` together with an attribute load in the same cycle: `clear` wins for `valid`, so the slot ends invalid. The attribute fields are still written.
- `rst` asserted mid-line: the next edge zeroes all slot state, including `valid`, `xcnt`, patterns and `s0`, and all outputs. Strobes during `rst` are ignored.
- A `next_pixel` strobe may occur on consecutive cycles. There is no minimum spacing.

## Test plan
- Reset, then 10 strobes with no loads -> `sprite_pixel` = 0, `sprite_priority` = 0 and `sprite0_pixel` = 0 throughout.
- Slot 2 loaded with attr = 0x21, X = 3, lo = 0x80, hi = 0x80 -> strobes 1-3 give 0; strobe 4 gives `sprite_pixel` = 4'b0111 with `sprite_priority` = 1; strobe 5 onward gives 0.
- Slot 0 loaded with attr = 0x40, lo = 0x01, X = 0 -> first strobe gives `sprite_pixel` = 4'b0001 (flip applied); strobes 2-8 give 0.
- Slots 1 and 3 both loaded with X = 0 and lo = 0xFF, with pal 1 and pal 3 respectively -> all 8 pixels = 4'b0101 (slot 1 wins). Then set slot 1's lo to 0x00 and reload -> pixels = 4'b1101.
- Slot 0 loaded with `sprite0_in` = 1, X = 5, hi = 0x80 -> `sprite0_pixel` = 1 only on strobe 6, with `sprite_pixel` = 4'b0010. Repeat with `clear` after the loads -> all outputs stay 0.
- Simultaneous X load (value 2) to slot 4 and strobe while slot 4 holds `xcnt` = 7 -> `xcnt` = 2 afterwards. Assert `rst` mid-pattern -> outputs = 0 on the next edge, and the slot stays inactive until reloaded.
